// File: rtl/processor_stage2.sv
//==============================================================================
// Module : processor_stage2
// Brief  : Operand stage - decode, register read with write-back forwarding,
//          ry+imm8 address generation and pipeline register into stage3.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module processor_stage2 #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] in_code_word,
    input  logic [ADDR_SIZE-1:0] in_ip,
    input  logic [ADDR_SIZE-1:0] in_ip_plus_one,
    input  logic                 stall,
    output logic [2:0]           reg_read_addr0,
    output logic [2:0]           reg_read_addr1,
    input  logic [WORD_SIZE-1:0] reg_read_data0,
    input  logic [WORD_SIZE-1:0] reg_read_data1,
    input  logic                 wb_enable,
    input  logic [2:0]           wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 call_performed,
    output logic [ADDR_SIZE-1:0] memory_addr,
    output logic                 memory_write_enable,
    output logic [WORD_SIZE-1:0] memory_write_data,
    output logic                 no_operation,
    output logic [WORD_SIZE-1:0] alu_data0,
    output logic [WORD_SIZE-1:0] alu_data1,
    output logic [ADDR_SIZE-1:0] data1_plus_imm8,
    output logic [ADDR_SIZE-1:0] code_word,
    output logic [ADDR_SIZE-1:0] ip,
    output logic [ADDR_SIZE-1:0] ip_plus_one
);

    localparam logic [3:0] OP_WRITE_TO_MEMORY = 4'd3;

    logic [3:0]           w_opcode;
    logic [2:0]           w_rx;
    logic [2:0]           w_ry;
    logic [ADDR_SIZE-1:0] w_imm_sext;
    logic [WORD_SIZE-1:0] w_rx_fwd;
    logic [WORD_SIZE-1:0] w_ry_fwd;
    logic [ADDR_SIZE-1:0] w_sum;

    logic                 nop_q,   nop_d;
    logic [WORD_SIZE-1:0] a0_q,    a0_d;
    logic [WORD_SIZE-1:0] a1_q,    a1_d;
    logic [ADDR_SIZE-1:0] sum_q,   sum_d;
    logic [ADDR_SIZE-1:0] cw_q,    cw_d;
    logic [ADDR_SIZE-1:0] ip_q,    ip_d;
    logic [ADDR_SIZE-1:0] ipp1_q,  ipp1_d;

    assign w_opcode   = in_code_word[17:14];
    assign w_rx       = in_code_word[13:11];
    assign w_ry       = in_code_word[10:8];
    assign w_imm_sext = {{(ADDR_SIZE-8){in_code_word[7]}}, in_code_word[7:0]};

    // Write-back forwarding also covers load-use: stage3 routes memory_out onto wb_data.
    assign w_rx_fwd = (wb_enable && wb_addr == w_rx) ? wb_data : reg_read_data0;
    assign w_ry_fwd = (wb_enable && wb_addr == w_ry) ? wb_data : reg_read_data1;
    assign w_sum    = ADDR_SIZE'(w_ry_fwd) + w_imm_sext;

    assign in_ready            = !stall;
    assign reg_read_addr0      = w_rx;
    assign reg_read_addr1      = w_ry;
    assign memory_addr         = w_sum;
    assign memory_write_data   = w_rx_fwd;
    assign memory_write_enable = reset && in_valid && in_ready && !call_performed
                                 && (w_opcode == OP_WRITE_TO_MEMORY);

    always_comb begin
        nop_d  = nop_q;
        a0_d   = a0_q;
        a1_d   = a1_q;
        sum_d  = sum_q;
        cw_d   = cw_q;
        ip_d   = ip_q;
        ipp1_d = ipp1_q;
        if (!stall) begin
            if (call_performed) begin
                nop_d  = 1'b1;
                a0_d   = '0;
                a1_d   = '0;
                sum_d  = '0;
                cw_d   = '0;
                ip_d   = '0;
                ipp1_d = '0;
            end else if (in_valid) begin
                nop_d  = 1'b0;
                a0_d   = w_rx_fwd;
                a1_d   = w_ry_fwd;
                sum_d  = w_sum;
                cw_d   = in_code_word;
                ip_d   = in_ip;
                ipp1_d = in_ip_plus_one;
            end else begin
                nop_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            nop_q  <= 1'b1;
            a0_q   <= '0;
            a1_q   <= '0;
            sum_q  <= '0;
            cw_q   <= '0;
            ip_q   <= '0;
            ipp1_q <= '0;
        end else begin
            nop_q  <= nop_d;
            a0_q   <= a0_d;
            a1_q   <= a1_d;
            sum_q  <= sum_d;
            cw_q   <= cw_d;
            ip_q   <= ip_d;
            ipp1_q <= ipp1_d;
        end
    end

    assign no_operation    = nop_q;
    assign alu_data0       = a0_q;
    assign alu_data1       = a1_q;
    assign data1_plus_imm8 = sum_q;
    assign code_word       = cw_q;
    assign ip              = ip_q;
    assign ip_plus_one     = ipp1_q;

endmodule

`default_nettype wire

// File: tb/tb_processor_stage2.sv
//==============================================================================
// Module : tb_processor_stage2
// Brief  : Directed plus randomized bench for processor_stage2 against a
//          behavioural pipeline-register model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_processor_stage2;

    localparam logic [3:0] OP_ALU = 4'd0;
    localparam logic [3:0] OP_WR  = 4'd3;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, stall, call_performed, wb_enable;
    logic [17:0] in_code_word, in_ip, in_ip_plus_one, wb_data;
    logic [2:0]  wb_addr, reg_read_addr0, reg_read_addr1;
    logic [17:0] reg_read_data0, reg_read_data1;
    logic [17:0] memory_addr, memory_write_data;
    logic        memory_write_enable, no_operation;
    logic [17:0] alu_data0, alu_data1, data1_plus_imm8, code_word, ip, ip_plus_one;

    logic [17:0] rf [8];
    int total = 0;
    int bad   = 0;

    // Expected pipeline-register contents
    logic        e_nop;
    logic [17:0] e_a0, e_a1, e_sum, e_cw, e_ip, e_ipp1;

    assign reg_read_data0 = rf[reg_read_addr0];
    assign reg_read_data1 = rf[reg_read_addr1];

    always #5 clock = ~clock;

    processor_stage2 #(.ADDR_SIZE(18), .WORD_SIZE(18)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_code_word(in_code_word), .in_ip(in_ip), .in_ip_plus_one(in_ip_plus_one),
        .stall(stall), .reg_read_addr0(reg_read_addr0), .reg_read_addr1(reg_read_addr1),
        .reg_read_data0(reg_read_data0), .reg_read_data1(reg_read_data1),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .call_performed(call_performed), .memory_addr(memory_addr),
        .memory_write_enable(memory_write_enable), .memory_write_data(memory_write_data),
        .no_operation(no_operation), .alu_data0(alu_data0), .alu_data1(alu_data1),
        .data1_plus_imm8(data1_plus_imm8), .code_word(code_word), .ip(ip),
        .ip_plus_one(ip_plus_one)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] operand(input logic [2:0] r);
        return (wb_enable && wb_addr == r) ? wb_data : rf[r];
    endfunction

    // Apply current inputs for one clock: check combinational outputs, then registers.
    task automatic step();
        logic [17:0] rxv, ryv, sum;
        logic        wr;
        int          s;
        #1;
        rxv = operand(in_code_word[13:11]);
        ryv = operand(in_code_word[10:8]);
        s   = int'(ryv) + int'($signed(in_code_word[7:0]));
        sum = 18'(s & 32'h3FFFF);
        wr  = reset && in_valid && !stall && !call_performed && in_code_word[17:14] == OP_WR;
        check("in_ready", {31'd0, in_ready}, {31'd0, !stall});
        check("rd_addr0", {29'd0, reg_read_addr0}, {29'd0, in_code_word[13:11]});
        check("rd_addr1", {29'd0, reg_read_addr1}, {29'd0, in_code_word[10:8]});
        check("mem_addr", {14'd0, memory_addr}, {14'd0, sum});
        check("mem_we", {31'd0, memory_write_enable}, {31'd0, wr});
        check("mem_wdata", {14'd0, memory_write_data}, {14'd0, rxv});
        if (!reset) begin
            e_nop = 1'b1; e_a0 = 0; e_a1 = 0; e_sum = 0; e_cw = 0; e_ip = 0; e_ipp1 = 0;
        end else if (stall) begin
            // hold
        end else if (call_performed) begin
            e_nop = 1'b1; e_a0 = 0; e_a1 = 0; e_sum = 0; e_cw = 0; e_ip = 0; e_ipp1 = 0;
        end else if (in_valid) begin
            e_nop = 1'b0; e_a0 = rxv; e_a1 = ryv; e_sum = sum;
            e_cw = in_code_word; e_ip = in_ip; e_ipp1 = in_ip_plus_one;
        end else begin
            e_nop = 1'b1;
        end
        @(posedge clock);
        #1;
        check("no_op", {31'd0, no_operation}, {31'd0, e_nop});
        check("alu0", {14'd0, alu_data0}, {14'd0, e_a0});
        check("alu1", {14'd0, alu_data1}, {14'd0, e_a1});
        check("d1imm", {14'd0, data1_plus_imm8}, {14'd0, e_sum});
        check("cw", {14'd0, code_word}, {14'd0, e_cw});
        check("ip", {14'd0, ip}, {14'd0, e_ip});
        check("ipp1", {14'd0, ip_plus_one}, {14'd0, e_ipp1});
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [2:0] rx,
                             input logic [2:0] ry, input logic [7:0] imm, input logic [17:0] pc);
        in_code_word   = {op, rx, ry, imm};
        in_ip          = pc;
        in_ip_plus_one = pc + 18'd1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 18'(i * 3);
        reset = 1'b0; in_valid = 1'b1; stall = 1'b0; call_performed = 1'b0;
        wb_enable = 1'b0; wb_addr = 3'd0; wb_data = 18'd0;
        set_instr(OP_WR, 3'd1, 3'd2, 8'h10, 18'h00100);
        e_nop = 1'b1; e_a0 = 0; e_a1 = 0; e_sum = 0; e_cw = 0; e_ip = 0; e_ipp1 = 0;

        // Reset held for two cycles with a valid store presented
        step();
        step();
        check("rst_no_op", {31'd0, no_operation}, 32'd1);
        check("rst_alu0", {14'd0, alu_data0}, 32'd0);
        reset = 1'b1;

        // Plain capture
        rf[2] = 18'd5; rf[3] = 18'h3FFFF;
        set_instr(OP_ALU, 3'd2, 3'd3, 8'h00, 18'h00200);
        step();
        check("cap_alu0", {14'd0, alu_data0}, 32'd5);
        check("cap_alu1", {14'd0, alu_data1}, 32'h3FFFF);

        // Immediate wrap in both directions
        rf[3] = 18'd1;
        set_instr(OP_ALU, 3'd2, 3'd3, 8'hFE, 18'h00201);
        step();
        check("wrap_neg", {14'd0, data1_plus_imm8}, 32'h3FFFF);
        rf[3] = 18'h3FFFF;
        set_instr(OP_ALU, 3'd2, 3'd3, 8'h01, 18'h00202);
        step();
        check("wrap_pos", {14'd0, data1_plus_imm8}, 32'h00000);

        // Forwarding hit and miss
        rf[4] = 18'd7;
        wb_enable = 1'b1; wb_addr = 3'd4; wb_data = 18'd99;
        set_instr(OP_ALU, 3'd4, 3'd4, 8'h00, 18'h00203);
        step();
        check("fwd_hit0", {14'd0, alu_data0}, 32'd99);
        check("fwd_hit1", {14'd0, alu_data1}, 32'd99);
        wb_addr = 3'd5;
        step();
        check("fwd_miss", {14'd0, alu_data0}, 32'd7);
        wb_enable = 1'b0;

        // Flush beats a valid store
        call_performed = 1'b1;
        set_instr(OP_WR, 3'd1, 3'd2, 8'h04, 18'h00300);
        step();
        check("flush_nop", {31'd0, no_operation}, 32'd1);
        call_performed = 1'b0;

        // Capture A, stall three cycles with B presented, release
        set_instr(OP_ALU, 3'd1, 3'd2, 8'h11, 18'h00400);
        step();
        stall = 1'b1;
        set_instr(OP_WR, 3'd3, 3'd4, 8'h22, 18'h00500);
        repeat (3) step();
        check("stall_ip", {14'd0, ip}, 32'h00400);
        stall = 1'b0;
        step();
        check("unstall_ip", {14'd0, ip}, 32'h00500);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rf[$urandom_range(0, 7)] = 18'($urandom);
            reset          = ($urandom_range(0, 31) != 0);
            in_valid       = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 3) == 0);
            call_performed = ($urandom_range(0, 7) == 0);
            wb_enable      = $urandom_range(0, 1) != 0;
            wb_addr        = 3'($urandom_range(0, 7));
            wb_data        = 18'($urandom);
            set_instr(($urandom_range(0, 2) == 0) ? OP_WR : 4'($urandom),
                      3'($urandom), 3'($urandom),
                      ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), 18'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/processor_stage2.md
Name: processor_stage2

Overview:
Operand stage of the 3-stage core, between instruction fetch (stage1) and the execute/write-back stage (processor_stage3).
- Decodes the fetched code word and reads rx/ry from the register file.
- Resolves read-after-write hazards by forwarding stage3's register write port.
- Computes ry+imm8 and issues the data-memory read/write address, so memory_out is valid while the instruction is in stage3.
- Registers everything stage3 consumes; handles flush on call and stall.

Parameters:
ADDR_SIZE, 18, instruction/data address width
WORD_SIZE, 18, data word width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset (sampled on clock edge; 0 = reset)
in_valid  in  1  stage1 presents a valid instruction
in_ready  out  1  stage2 accepts the instruction this cycle
in_code_word  in  ADDR_SIZE  fetched instruction
in_ip  in  ADDR_SIZE  address of fetched instruction
in_ip_plus_one  in  ADDR_SIZE  in_ip+1
stall  in  1  downstream/memory busy; freeze stage2
reg_read_addr0  out  3  = in_code_word[13:11] (rx)
reg_read_addr1  out  3  = in_code_word[10:8] (ry)
reg_read_data0  in  WORD_SIZE  register file async read of addr0
reg_read_data1  in  WORD_SIZE  register file async read of addr1
wb_enable  in  1  stage3 reg_write_enable
wb_addr  in  3  stage3 reg_write_addr
wb_data  in  WORD_SIZE  stage3 reg_write_data
call_performed  in  1  stage3 redirect; flush
memory_addr  out  ADDR_SIZE  data memory address (combinational, ry_fwd+imm8)
memory_write_enable  out  1  store strobe
memory_write_data  out  WORD_SIZE  store data (rx_fwd)
no_operation  out  1  registered; bubble marker to stage3
alu_data0  out  WORD_SIZE  registered rx value
alu_data1  out  WORD_SIZE  registered ry value
data1_plus_imm8  out  ADDR_SIZE  registered ry+sext(imm8)
code_word  out  ADDR_SIZE  registered instruction
ip  out  ADDR_SIZE  registered in_ip
ip_plus_one  out  ADDR_SIZE  registered in_ip_plus_one

Behaviour:
- Field decode:
  - opcode = [17:14], rx = [13:11], ry = [10:8].
  - imm8 = [7:0], sign-extended to ADDR_SIZE.
- Forwarding:
  - rx_fwd = wb_data if wb_enable && wb_addr==rx, else reg_read_data0.
  - ry_fwd is formed the same way against ry.
  - Forwarding covers the load-use case: stage3 drives memory_out through wb_data in the same cycle.
- Arithmetic: sum = ry_fwd + sext(imm8), truncated to ADDR_SIZE (modulo 2^18 wrap).
- memory_addr = sum, combinational.
- memory_write_enable = in_valid && in_ready && opcode==OP_WRITE_TO_MEMORY && !call_performed.
  - The write commits at the same clock edge the instruction is accepted.
- in_ready = !stall. Transfer happens when in_valid && in_ready.
- Output registers, updated on each rising edge, highest priority first:
  - reset==0: no_operation=1; all data outputs, code_word, ip and ip_plus_one = 0.
  - else if stall: all outputs hold.
  - else if call_performed: no_operation=1; other outputs don't-care but are cleared to 0. Flush wins over a simultaneous valid input, and that input is dropped (stage1 refetches).
  - else if in_valid: no_operation=0; alu_data0=rx_fwd, alu_data1=ry_fwd, data1_plus_imm8=sum; code_word, ip and ip_plus_one latched.
  - else: no_operation=1 (bubble).
- Latency: exactly 1 cycle from accepted input to stage3 inputs.
- Stall while stage3 holds a valid instruction:
  - Stage3 re-executes from identical inputs each cycle.
  - The wb_* forward path is still sampled only when capturing a new instruction.
- Reset mid-stall: reset wins; no_operation=1 next cycle.
- Reset asserted: memory_write_enable=0.
- OP_WAIT and all other opcodes pass through unchanged; stage3 interprets them.

Test Plan:
- Reset: reset=0 two cycles with in_valid=1 -> no_operation=1, alu_data0=0, memory_write_enable=0.
- Plain capture: r2=5, r3=0x3FFFF, code word OP_ALU rx=2 ry=3, no wb -> next cycle alu_data0=5, alu_data1=0x3FFFF, no_operation=0, ip latched.
- Imm wrap: ry=0x00001, imm8=0xFE (-2) -> data1_plus_imm8=0x3FFFF; ry=0x3FFFF, imm8=0x01 -> 0x00000.
- Forwarding: regfile r4=7 while wb_enable=1, wb_addr=4, wb_data=99, instruction reads rx=ry=4 -> alu_data0=alu_data1=99; repeat with wb_addr=5 -> 7.
- Flush: call_performed=1 with in_valid=1 OP_WRITE_TO_MEMORY -> memory_write_enable=0, next no_operation=1.
- Stall: capture instruction A, then stall=1 for 3 cycles with new input B -> in_ready=0, outputs hold A; stall=0 -> B captured next edge.
